// File: rtl/alu_instr_sequencer.sv
// Byte-stream instruction sequencer between the UART, register file and 8-bit ALU.
// Optional build macro INSTR_TIMEOUT_EN discards a stalled partial instruction.
module alu_instr_sequencer #(
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] instr_o,
  output logic [3:0]  rf_rs1_addr,
  output logic [3:0]  rf_rs2_addr,
  input  logic [7:0]  alu_result,
  input  logic        alu_write_ctrl,
  input  logic        alu_read_en,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        instr_done
);

  // state   | meaning
  // COLLECT | accepting instruction bytes from the receiver
  // ISSUE   | instruction and read addresses presented, ALU registers its outputs
  // EXEC    | ALU result captured, commit path chosen
  // WB      | one-cycle register-file write-back
  // TX      | result byte offered to the transmitter until accepted
  typedef enum logic [2:0] {
    S_COLLECT,
    S_ISSUE,
    S_EXEC,
    S_WB,
    S_TX
  } state_t;

  typedef struct packed {
    logic [8:0] empty;
    logic [3:0] rd;
    logic [3:0] rs2;
    logic [3:0] rs1;
    logic [7:0] imm;
    logic [2:0] opcode;
  } yongatek_instruction_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q;
  yongatek_instruction_t instr_q;
  logic [7:0]            result_q;
  logic                  done_q;
  logic                  live_q;
  logic                  accept;
  logic                  timeout;

  // live_q keeps rx_ready low until the first clock after reset release
  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_COLLECT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (accept && byte_cnt_q == 2'd3) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_EXEC;
      S_EXEC: begin
        if (alu_write_ctrl)   state_d = S_WB;
        else if (alu_read_en) state_d = S_TX;
        else                  state_d = S_COLLECT;
      end
      S_WB:      state_d = S_COLLECT;
      S_TX:      if (tx_ready) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    rx_ready    = live_q && (state_q == S_COLLECT);
    busy        = (state_q != S_COLLECT);
    rf_we       = (state_q == S_WB);
    rf_wdata    = (state_q == S_WB) ? result_q : 8'h00;
    tx_valid    = (state_q == S_TX);
    tx_data     = (state_q == S_TX) ? result_q : 8'h00;
    instr_done  = done_q;
    instr_o     = instr_q;
    rf_rs1_addr = instr_q.rs1;
    rf_rs2_addr = instr_q.rs2;
    rf_waddr    = instr_q.rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= 2'd0;
      instr_q    <= '0;
      result_q   <= 8'h00;
      done_q     <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        instr_q[8*byte_cnt_q +: 8] <= rx_data;
        byte_cnt_q                 <= byte_cnt_q + 2'd1;
      end else if (timeout) begin
        byte_cnt_q <= 2'd0;
      end
      if (state_q == S_EXEC) result_q <= alu_result;
      done_q <= (state_q == S_WB)
             || (state_q == S_TX && tx_ready)
             || (state_q == S_EXEC && !alu_write_ctrl && !alu_read_en);
    end
  end

`ifdef INSTR_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (state_q == S_COLLECT) && (byte_cnt_q != 2'd0) && !accept
                && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // counts idle clocks between bytes of a partially received instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt_q <= '0;
    else if (state_q != S_COLLECT || accept || byte_cnt_q == 2'd0 || timeout)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  logic [TO_W-1:0] unused_to_cfg;

  assign timeout       = 1'b0;
  assign unused_to_cfg = TO_W'(TIMEOUT_CYCLES);
`endif

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Sequences the 8-bit ALU datapath from a byte stream delivered by the UART receiver. Assembles four received bytes into one 32-bit yongatek_instruction_t and presents it, with register-file read addresses, to the ALU. Then commits the result, either as a register-file write-back or as a byte handed to the UART transmitter. Sits between uart_rx/uart_tx, register_file and ALU; only one instruction is in flight at a time.

Parameters:
TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes of one instruction (used only with INSTR_TIMEOUT_EN)
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-low reset (asserted at 0)
rx_valid  input  1  received byte valid
rx_data  input  8  received byte
rx_ready  output  1  sequencer accepts a byte this cycle
instr_o  output  32  assembled instruction (yongatek_instruction_t) to ALU
rf_rs1_addr  output  4  register-file read port 1 address (= instr_o.rs1)
rf_rs2_addr  output  4  register-file read port 2 address (= instr_o.rs2)
alu_result  input  8  ALU_o
alu_write_ctrl  input  1  ALU write_ctrl
alu_read_en  input  1  ALU read_data_en
rf_we  output  1  register-file write enable, one-cycle pulse
rf_waddr  output  4  write address (= instr_o.rd)
rf_wdata  output  8  write data
tx_valid  output  1  byte offered to UART transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  transmitter accepts byte
busy  output  1  high in every state except COLLECT
instr_done  output  1  one-cycle pulse per retired instruction

Behaviour:
- Reset (rst=0, async): state COLLECT, byte count 0, instr_o=0, result reg=0. Outputs: rx_ready=0, rf_we=0, tx_valid=0, tx_data=0, rf_wdata=0, busy=0, instr_done=0. rx_ready rises the first cycle after deassertion.
- Field map of instr_o: [31:23] empty, [22:19] rd, [18:15] rs2, [14:11] rs1, [10:3] imm, [2:0] opcode.
- COLLECT: rx_ready=1. On rx_valid&&rx_ready, byte k (k=0..3) loads instr_o[8k+7:8k] (little-endian, first byte is LSB) and count increments. After byte 3, count wraps to 0 and state goes to ISSUE. instr_o is only updated in COLLECT.
- ISSUE (1 cycle): instr_o and read addresses stable; register_file read is combinational, and the ALU registers its outputs at the end of this cycle.
- EXEC (1 cycle): sample alu_result into the result reg.
  - alu_write_ctrl=1 -> WB.
  - Else alu_read_en=1 -> TX.
  - Neither -> COLLECT with instr_done pulse (defensive path, no commit).
- WB (1 cycle): rf_we=1, rf_waddr=instr_o.rd, rf_wdata=result reg. Next COLLECT.
- TX: tx_valid=1, tx_data=result reg, both held stable until tx_ready=1. Handshake completes on tx_valid&&tx_ready; next COLLECT. tx_valid must not drop before the handshake.
- instr_done: registered pulse in the first COLLECT cycle after WB, after the TX handshake, or after the defensive path.
- Latency: last byte accepted at edge N. ISSUE runs in cycle N+1, EXEC in N+2, WB with rf_we in N+3, and COLLECT with instr_done and rx_ready=1 in N+4.
- rx bytes arriving while busy are not accepted (rx_ready=0). The receiver holds or drops them; no overrun state exists here.
- All outputs are Moore decodes of registered state/data; no combinational path from any input to any output.

Optional Feature:
INSTR_TIMEOUT_EN
- Defined: in COLLECT with count≠0, a counter increments each cycle without an accepted byte and clears on each accepted byte. When it reaches TIMEOUT_CYCLES, count resets to 0 and the partial instruction is discarded. instr_o bytes are overwritten by the next stream; no instr_done. Counter is cleared on entry to COLLECT and at reset.
- Undefined: no counter logic; a partial instruction waits indefinitely.

Test Plan:
- WR_rf: bytes D6 02 18 00 (0x001802D6: rd=3, imm=0x5A) with ALU model -> rf_we single cycle, waddr 3, wdata 0x5A exactly 3 cycles after the last byte; instr_done next cycle; no tx_valid.
- ADD: r1=0x10, r2=0x22; bytes 00 08 21 00 (rd=4, rs2=2, rs1=1) -> rf_rs1_addr=1, rf_rs2_addr=2 in ISSUE; rf_we with waddr 4, wdata 0x32.
- RD_rf with backpressure: bytes 07 20 00 00 (rs1=4, r4=0x32); tx_ready low 5 cycles then high -> tx_valid high 6 cycles, tx_data=0x32 stable throughout, rf_we never asserted, rx_ready=0 until after the handshake.
- Back-to-back: SUB then SLL (imm=2) streamed with rx_valid always high -> rx_ready low from ISSUE through WB; both results written in order; two instr_done pulses.
- Reset mid-TX: rst=0 while tx_valid=1 -> tx_valid, busy and instr_done drop immediately (async). After release, state is COLLECT with count 0 and the next 4 bytes decode correctly.
- INSTR_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 2 bytes, idle 16 cycles, then send D6 02 18 00 -> single WR_rf to r3 with 0x5A; no corrupted instruction issued.
